// File: rtl/match_controller_pkg.sv
//------------------------------------------------------------------------------
// fight_pkg
// Action encodings, FSM state codes, winner codes and the action validity
// helper shared by the match controller and its action latches.
// Optional feature macro: PAUSE_EN (adds the PAUSED state code).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fight_pkg;

   // One-hot actions, MSB = Wait
   localparam logic [5:0] ACT_WAIT       = 6'b100000;
   localparam logic [5:0] ACT_MOVE_LEFT  = 6'b010000;
   localparam logic [5:0] ACT_MOVE_RIGHT = 6'b001000;
   localparam logic [5:0] ACT_JUMP       = 6'b000100;
   localparam logic [5:0] ACT_PUNCH      = 6'b000010;
   localparam logic [5:0] ACT_KICK       = 6'b000001;

   // FSM state codes
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_COUNTDOWN  = 3'd1;
   localparam logic [2:0] ST_FIGHT      = 3'd2;
   localparam logic [2:0] ST_ROUND_END  = 3'd3;
   localparam logic [2:0] ST_MATCH_OVER = 3'd4;
`ifdef PAUSE_EN
   localparam logic [2:0] ST_PAUSED     = 3'd5;
`endif

   // Round / match winner codes
   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_e;

   // True only for exactly one of the six legal one-hot actions
   function automatic logic valid_action(input logic [5:0] a);
      return (a == ACT_WAIT)  || (a == ACT_MOVE_LEFT) || (a == ACT_MOVE_RIGHT) ||
             (a == ACT_JUMP)  || (a == ACT_PUNCH)     || (a == ACT_KICK);
   endfunction

endpackage

`default_nettype wire

// File: rtl/match_controller_if.sv
//------------------------------------------------------------------------------
// match_controller_if
// Bundles the tick/start/player/health inputs and the command, score and
// status outputs of the match controller.
// Optional feature macro: PAUSE_EN (adds the pause input).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface match_controller_if;
   logic       tick;
   logic       start;
   logic [5:0] player1_in;
   logic [5:0] player2_in;
   logic [1:0] player1_health;
   logic [1:0] player2_health;
`ifdef PAUSE_EN
   logic       pause;
`endif
   logic [5:0] player1_cmd;
   logic [5:0] player2_cmd;
   logic       core_reset;
   logic [6:0] round_timer;
   logic [2:0] round_num;
   logic [1:0] p1_rounds;
   logic [1:0] p2_rounds;
   logic       match_over;
   logic [1:0] match_winner;

   // Driver side: input layer, core feedback and observers
   modport master (
      output tick, start, player1_in, player2_in, player1_health, player2_health,
`ifdef PAUSE_EN
      output pause,
`endif
      input  player1_cmd, player2_cmd, core_reset, round_timer, round_num,
      input  p1_rounds, p2_rounds, match_over, match_winner
   );

   // Controller side
   modport slave (
      input  tick, start, player1_in, player2_in, player1_health, player2_health,
`ifdef PAUSE_EN
      input  pause,
`endif
      output player1_cmd, player2_cmd, core_reset, round_timer, round_num,
      output p1_rounds, p2_rounds, match_over, match_winner
   );
endinterface

`default_nettype wire

// File: rtl/match_controller_action_latch.sv
//------------------------------------------------------------------------------
// action_latch
// Holds the most recent valid one-hot action of one player, drives it to the
// core for the issuing tick cycle only and returns to Wait afterwards.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module action_latch
   import fight_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] action_i,   // raw action from the input layer
   input  logic       issue_i,    // FIGHT tick cycle: present the held action
   input  logic       flush_i,    // force the held action back to Wait
   output logic [5:0] cmd_o
);

   logic [5:0] hold_q;
   logic [5:0] hold_d;

   // A fresh valid action beats the post-issue clear so a press landing on the
   // tick cycle is kept for the next tick; flush beats everything.
   always_comb begin
      hold_d = hold_q;
      if (flush_i)
         hold_d = ACT_WAIT;
      else if (valid_action(action_i))
         hold_d = action_i;
      else if (issue_i)
         hold_d = ACT_WAIT;
   end

   // Hold register
   always_ff @(posedge clock) begin
      if (reset) hold_q <= ACT_WAIT;
      else       hold_q <= hold_d;
   end

   assign cmd_o = issue_i ? hold_q : ACT_WAIT;

endmodule

`default_nettype wire

// File: rtl/match_controller.sv
//------------------------------------------------------------------------------
// match_controller
// Best-of-N match sequencer: countdown, round timer, KO / time-out decisions,
// round score, core reset pulses and per-tick command issue.
// Optional feature macro: PAUSE_EN (pause input and PAUSED state).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module match_controller
   import fight_pkg::*;
#(
   parameter int ROUNDS_TO_WIN   = 2,
   parameter int MAX_ROUNDS      = 5,
   parameter int ROUND_TICKS     = 60,
   parameter int COUNTDOWN_TICKS = 3,
   parameter int END_TICKS       = 2
)(
   input  logic               clock,
   input  logic               reset,
   match_controller_if.slave  bus
);

   localparam logic [7:0] CD_LAST    = 8'(COUNTDOWN_TICKS - 1);
   localparam logic [7:0] END_LAST   = 8'(END_TICKS - 1);
   localparam logic [6:0] TIMER_INIT = 7'(ROUND_TICKS);
   localparam logic [1:0] WIN_SCORE  = 2'(ROUNDS_TO_WIN);
   localparam logic [2:0] LAST_ROUND = 3'(MAX_ROUNDS);

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [6:0] timer_q, timer_d;
   logic [2:0] round_q, round_d;
   logic [1:0] p1s_q, p1s_d;
   logic [1:0] p2s_q, p2s_d;
   logic       core_rst_q, core_rst_d;

   logic       issue;
   logic       flush;
   logic       ko;
   logic       fight_end;
   winner_e    rnd_win;
   logic       pause_rise;

`ifdef PAUSE_EN
   logic pause_q;

   // Previous pause level for edge detection
   always_ff @(posedge clock) begin
      if (reset) pause_q <= 1'b0;
      else       pause_q <= bus.pause;
   end
   assign pause_rise = bus.pause & ~pause_q;
   assign flush      = (state_q == ST_PAUSED);
`else
   assign pause_rise = 1'b0;
   assign flush      = 1'b0;
`endif

   // Commands reach the core only on a FIGHT tick, never while reset is applied
   assign issue = !reset && (state_q == ST_FIGHT) && bus.tick;

   action_latch u_latch_p1 (
      .clock    (clock),
      .reset    (reset),
      .action_i (bus.player1_in),
      .issue_i  (issue),
      .flush_i  (flush),
      .cmd_o    (bus.player1_cmd)
   );

   action_latch u_latch_p2 (
      .clock    (clock),
      .reset    (reset),
      .action_i (bus.player2_in),
      .issue_i  (issue),
      .flush_i  (flush),
      .cmd_o    (bus.player2_cmd)
   );

   // Round outcome from current health; a KO overrides the time-out comparison
   always_comb begin
      ko      = (bus.player1_health == 2'd0) || (bus.player2_health == 2'd0);
      rnd_win = WIN_DRAW;
      if (ko) begin
         if ((bus.player1_health == 2'd0) && (bus.player2_health == 2'd0)) rnd_win = WIN_DRAW;
         else if (bus.player2_health == 2'd0)                              rnd_win = WIN_P1;
         else                                                              rnd_win = WIN_P2;
      end else if (bus.player1_health > bus.player2_health) begin
         rnd_win = WIN_P1;
      end else if (bus.player2_health > bus.player1_health) begin
         rnd_win = WIN_P2;
      end
      fight_end = ko || (timer_q == 7'd0);
   end

   // Match sequencing next-state logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      timer_d    = timer_q;
      round_d    = round_q;
      p1s_d      = p1s_q;
      p2s_d      = p2s_q;
      core_rst_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_MATCH_OVER: begin
            if (bus.start) begin
               state_d    = ST_COUNTDOWN;
               round_d    = 3'd1;
               p1s_d      = 2'd0;
               p2s_d      = 2'd0;
               cnt_d      = 8'd0;
               timer_d    = TIMER_INIT;
               core_rst_d = 1'b1;
            end
         end
         ST_COUNTDOWN: begin
            if (bus.tick) begin
               if (cnt_q == CD_LAST) begin
                  state_d = ST_FIGHT;
                  timer_d = TIMER_INIT;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_FIGHT: begin
            if (fight_end) begin
               state_d = ST_ROUND_END;
               cnt_d   = 8'd0;
               if ((rnd_win == WIN_P1) && (p1s_q != WIN_SCORE)) p1s_d = p1s_q + 2'd1;
               if ((rnd_win == WIN_P2) && (p2s_q != WIN_SCORE)) p2s_d = p2s_q + 2'd1;
            end else if (pause_rise) begin
`ifdef PAUSE_EN
               state_d = ST_PAUSED;
`endif
            end else if (bus.tick) begin
               timer_d = timer_q - 7'd1;
            end
         end
`ifdef PAUSE_EN
         ST_PAUSED: begin
            if (pause_rise) state_d = ST_FIGHT;
         end
`endif
         ST_ROUND_END: begin
            if (bus.tick) begin
               if (cnt_q == END_LAST) begin
                  if ((p1s_q == WIN_SCORE) || (p2s_q == WIN_SCORE) || (round_q == LAST_ROUND)) begin
                     state_d = ST_MATCH_OVER;
                  end else begin
                     state_d    = ST_COUNTDOWN;
                     round_d    = round_q + 3'd1;
                     cnt_d      = 8'd0;
                     timer_d    = TIMER_INIT;
                     core_rst_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; the core is held in reset alongside the controller
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         timer_q    <= TIMER_INIT;
         round_q    <= 3'd0;
         p1s_q      <= 2'd0;
         p2s_q      <= 2'd0;
         core_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         round_q    <= round_d;
         p1s_q      <= p1s_d;
         p2s_q      <= p2s_d;
         core_rst_q <= core_rst_d;
      end
   end

   assign bus.core_reset   = core_rst_q;
   assign bus.round_timer  = timer_q;
   assign bus.round_num    = round_q;
   assign bus.p1_rounds    = p1s_q;
   assign bus.p2_rounds    = p2s_q;
   assign bus.match_over   = (state_q == ST_MATCH_OVER);
   assign bus.match_winner = (state_q != ST_MATCH_OVER) ? WIN_NONE :
                             (p1s_q > p2s_q)            ? WIN_P1   :
                             (p2s_q > p1s_q)            ? WIN_P2   : WIN_DRAW;

endmodule

`default_nettype wire

// File: tb/tb_match_controller.sv
//------------------------------------------------------------------------------
// tb_match_controller
// Self-checking bench for match_controller: scenario tasks with inline checks,
// command expectations queued at stimulus time and popped on issuing ticks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_match_controller;
   import fight_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   match_controller_if bus ();

   match_controller dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [5:0] cmd1_s, cmd2_s;
   logic [5:0] q1[$];
   logic [5:0] q2[$];
   logic [5:0] exp1, exp2;
   logic [6:0] exp_timer;

   // Action stimulus table: two drive cycles per entry, then an issuing tick
   logic [5:0] tA1[6] = '{ACT_PUNCH, 6'd0, ACT_JUMP,      6'b000011, ACT_MOVE_RIGHT, 6'd0};
   logic [5:0] tB1[6] = '{6'd0,      6'd0, ACT_MOVE_LEFT, 6'd0,      6'b000011,      6'd0};
   logic [5:0] tA2[6] = '{6'd0,      6'd0, ACT_KICK,      6'b110000, 6'd0,           ACT_KICK};
   logic [5:0] tB2[6] = '{6'd0,      6'd0, 6'd0,          6'd0,      ACT_WAIT,       6'd0};
   logic [5:0] tE1[6] = '{ACT_PUNCH, ACT_WAIT, ACT_MOVE_LEFT, ACT_WAIT, ACT_MOVE_RIGHT, ACT_WAIT};
   logic [5:0] tE2[6] = '{ACT_WAIT,  ACT_WAIT, ACT_KICK,      ACT_WAIT, ACT_WAIT,       ACT_KICK};

   // One clock cycle: set tick, capture commands mid-cycle, end on the next negedge
   task automatic step(input logic t);
      bus.tick = t;
      #1;
      cmd1_s = bus.player1_cmd;
      cmd2_s = bus.player2_cmd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic countdown();
      for (int k = 0; k < 3; k++) step(1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b1);
      step(1'b0);
      n_checks++; if (bus.core_reset !== 1'b1) $display("FAIL reset_core_reset: got %0b want 1", bus.core_reset); else n_pass++;
      n_checks++; if (bus.round_timer !== 7'd60) $display("FAIL reset_timer: got %0d want 60", bus.round_timer); else n_pass++;
      n_checks++; if (bus.round_num !== 3'd0) $display("FAIL reset_round_num: got %0d want 0", bus.round_num); else n_pass++;
      n_checks++; if ({bus.p1_rounds, bus.p2_rounds} !== 4'd0) $display("FAIL reset_scores: got %0d/%0d want 0/0", bus.p1_rounds, bus.p2_rounds); else n_pass++;
      n_checks++; if ({bus.match_over, bus.match_winner} !== 3'd0) $display("FAIL reset_match: got over=%0b win=%0b want 0/00", bus.match_over, bus.match_winner); else n_pass++;
      n_checks++; if ({cmd1_s, cmd2_s} !== {ACT_WAIT, ACT_WAIT}) $display("FAIL reset_cmds: got %b/%b want Wait", cmd1_s, cmd2_s); else n_pass++;
      rst = 1'b0;
      step(1'b0);
      n_checks++; if (bus.core_reset !== 1'b0) $display("FAIL reset_core_release: got %0b want 0", bus.core_reset); else n_pass++;
   endtask

   task automatic test_start();
      int pulses = 0;
      bus.start = 1'b1;
      step(1'b0);
      bus.start = 1'b0;
      if (bus.core_reset === 1'b1) pulses++;
      n_checks++; if (bus.round_num !== 3'd1) $display("FAIL start_round_num: got %0d want 1", bus.round_num); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         step(1'b0);
         if (bus.core_reset === 1'b1) pulses++;
         step(1'b1);
         if (bus.core_reset === 1'b1) pulses++;
      end
      n_checks++; if (pulses != 1) $display("FAIL start_core_reset_pulses: got %0d want 1", pulses); else n_pass++;
      n_checks++; if (bus.round_timer !== 7'd60) $display("FAIL start_timer_at_fight: got %0d want 60", bus.round_timer); else n_pass++;
      step(1'b1);
      exp_timer = 7'd59;
      n_checks++; if (bus.round_timer !== exp_timer) $display("FAIL start_first_decrement: got %0d want %0d", bus.round_timer, exp_timer); else n_pass++;
   endtask

   task automatic test_actions();
      for (int i = 0; i < 6; i++) begin
         bus.player1_in = tA1[i];
         bus.player2_in = tA2[i];
         step(1'b0);
         n_checks++; if (cmd1_s !== ACT_WAIT) $display("FAIL act_idle_cycle[%0d]: got %b want %b", i, cmd1_s, ACT_WAIT); else n_pass++;
         bus.player1_in = tB1[i];
         bus.player2_in = tB2[i];
         step(1'b0);
         bus.player1_in = 6'd0;
         bus.player2_in = 6'd0;
         q1.push_back(tE1[i]);
         q2.push_back(tE2[i]);
         step(1'b1);
         exp_timer = exp_timer - 7'd1;
         exp1 = q1.pop_front();
         exp2 = q2.pop_front();
         n_checks++; if (cmd1_s !== exp1) $display("FAIL act_p1_cmd[%0d]: got %b want %b", i, cmd1_s, exp1); else n_pass++;
         n_checks++; if (cmd2_s !== exp2) $display("FAIL act_p2_cmd[%0d]: got %b want %b", i, cmd2_s, exp2); else n_pass++;
         n_checks++; if (bus.round_timer !== exp_timer) $display("FAIL act_timer[%0d]: got %0d want %0d", i, bus.round_timer, exp_timer); else n_pass++;
      end
      bus.start = 1'b1;
      step(1'b0);
      bus.start = 1'b0;
      n_checks++; if ({bus.round_num, bus.core_reset} !== {3'd1, 1'b0}) $display("FAIL start_ignored_in_fight: got round=%0d core_reset=%0b want 1/0", bus.round_num, bus.core_reset); else n_pass++;
   endtask

   task automatic test_ko();
      bus.player2_health = 2'd0;
      step(1'b0);
      bus.player2_health = 2'd3;
      n_checks++; if ({bus.p1_rounds, bus.p2_rounds} !== {2'd1, 2'd0}) $display("FAIL ko_scores: got %0d/%0d want 1/0", bus.p1_rounds, bus.p2_rounds); else n_pass++;
      step(1'b1);
      n_checks++; if ({bus.round_num, bus.core_reset} !== {3'd1, 1'b0}) $display("FAIL ko_end_first_tick: got round=%0d core_reset=%0b want 1/0", bus.round_num, bus.core_reset); else n_pass++;
      n_checks++; if (cmd1_s !== ACT_WAIT) $display("FAIL ko_end_cmd: got %b want %b", cmd1_s, ACT_WAIT); else n_pass++;
      step(1'b1);
      n_checks++; if ({bus.round_num, bus.core_reset} !== {3'd2, 1'b1}) $display("FAIL ko_next_round: got round=%0d core_reset=%0b want 2/1", bus.round_num, bus.core_reset); else n_pass++;
      step(1'b0);
      n_checks++; if (bus.core_reset !== 1'b0) $display("FAIL ko_pulse_width: got %0b want 0", bus.core_reset); else n_pass++;
      countdown();
   endtask

   task automatic test_draw_timeout();
      bus.player1_health = 2'd2;
      bus.player2_health = 2'd2;
      for (int k = 0; k < 60; k++) step(1'b1);
      n_checks++; if (bus.round_timer !== 7'd0) $display("FAIL draw_timer_zero: got %0d want 0", bus.round_timer); else n_pass++;
      step(1'b0);
      n_checks++; if ({bus.p1_rounds, bus.p2_rounds} !== {2'd1, 2'd0}) $display("FAIL draw_scores: got %0d/%0d want 1/0", bus.p1_rounds, bus.p2_rounds); else n_pass++;
      step(1'b1);
      step(1'b1);
      n_checks++; if (bus.round_num !== 3'd3) $display("FAIL draw_next_round: got %0d want 3", bus.round_num); else n_pass++;
      countdown();
   endtask

   task automatic test_ko_beats_timeout();
      bus.player1_health = 2'd3;
      bus.player2_health = 2'd2;
      for (int k = 0; k < 60; k++) step(1'b1);
      bus.player1_health = 2'd0;
      step(1'b0);
      bus.player1_health = 2'd3;
      n_checks++; if ({bus.p1_rounds, bus.p2_rounds} !== {2'd1, 2'd1}) $display("FAIL ko_vs_timeout_scores: got %0d/%0d want 1/1", bus.p1_rounds, bus.p2_rounds); else n_pass++;
      step(1'b1);
      step(1'b1);
      n_checks++; if (bus.round_num !== 3'd4) $display("FAIL ko_vs_timeout_round: got %0d want 4", bus.round_num); else n_pass++;
      countdown();
   endtask

   task automatic test_timeout_win();
      bus.player1_health = 2'd3;
      bus.player2_health = 2'd2;
      for (int k = 0; k < 60; k++) step(1'b1);
      step(1'b0);
      n_checks++; if ({bus.p1_rounds, bus.p2_rounds} !== {2'd2, 2'd1}) $display("FAIL timeout_scores: got %0d/%0d want 2/1", bus.p1_rounds, bus.p2_rounds); else n_pass++;
      step(1'b1);
      n_checks++; if (bus.match_over !== 1'b0) $display("FAIL timeout_over_early: got %0b want 0", bus.match_over); else n_pass++;
      step(1'b1);
      n_checks++; if ({bus.match_over, bus.match_winner} !== {1'b1, WIN_P1}) $display("FAIL timeout_match: got over=%0b win=%b want 1/01", bus.match_over, bus.match_winner); else n_pass++;
      n_checks++; if ({bus.round_num, bus.core_reset} !== {3'd4, 1'b0}) $display("FAIL timeout_final_round: got round=%0d core_reset=%0b want 4/0", bus.round_num, bus.core_reset); else n_pass++;
   endtask

   task automatic test_p2_match();
      step(1'b1);
      n_checks++; if (bus.match_over !== 1'b1) $display("FAIL over_holds: got %0b want 1", bus.match_over); else n_pass++;
      bus.start = 1'b1;
      step(1'b0);
      bus.start = 1'b0;
      n_checks++; if ({bus.round_num, bus.p1_rounds, bus.p2_rounds} !== {3'd1, 2'd0, 2'd0}) $display("FAIL restart_state: got round=%0d scores=%0d/%0d want 1 0/0", bus.round_num, bus.p1_rounds, bus.p2_rounds); else n_pass++;
      n_checks++; if ({bus.match_over, bus.match_winner} !== 3'd0) $display("FAIL restart_match: got over=%0b win=%b want 0/00", bus.match_over, bus.match_winner); else n_pass++;
      for (int r = 1; r <= 2; r++) begin
         countdown();
         bus.player1_health = 2'd0;
         step(1'b0);
         bus.player1_health = 2'd3;
         n_checks++; if (bus.p2_rounds !== 2'(r)) $display("FAIL p2_score[%0d]: got %0d want %0d", r, bus.p2_rounds, r); else n_pass++;
         step(1'b1);
         step(1'b1);
      end
      n_checks++; if ({bus.match_over, bus.match_winner, bus.round_num} !== {1'b1, WIN_P2, 3'd2}) $display("FAIL p2_match: got over=%0b win=%b round=%0d want 1/10/2", bus.match_over, bus.match_winner, bus.round_num); else n_pass++;
   endtask

   task automatic test_round_cap();
      bus.start = 1'b1;
      step(1'b0);
      bus.start = 1'b0;
      for (int r = 1; r <= 5; r++) begin
         countdown();
         bus.player1_health = 2'd0;
         bus.player2_health = 2'd0;
         step(1'b0);
         bus.player1_health = 2'd3;
         bus.player2_health = 2'd3;
         n_checks++; if ({bus.p1_rounds, bus.p2_rounds} !== 4'd0) $display("FAIL cap_draw_scores[%0d]: got %0d/%0d want 0/0", r, bus.p1_rounds, bus.p2_rounds); else n_pass++;
         step(1'b1);
         step(1'b1);
         if (r < 5) begin
            n_checks++; if (bus.round_num !== 3'(r + 1)) $display("FAIL cap_round[%0d]: got %0d want %0d", r, bus.round_num, r + 1); else n_pass++;
         end
      end
      n_checks++; if ({bus.match_over, bus.match_winner, bus.round_num} !== {1'b1, WIN_DRAW, 3'd5}) $display("FAIL cap_match: got over=%0b win=%b round=%0d want 1/11/5", bus.match_over, bus.match_winner, bus.round_num); else n_pass++;
   endtask

   task automatic test_reset_mid_round();
      bus.start = 1'b1;
      step(1'b0);
      bus.start = 1'b0;
      countdown();
      bus.player1_in = ACT_KICK;
      bus.player2_in = ACT_PUNCH;
      step(1'b0);
      bus.player1_in = 6'd0;
      bus.player2_in = 6'd0;
      rst = 1'b1;
      step(1'b1);
      n_checks++; if ({cmd1_s, cmd2_s} !== {ACT_WAIT, ACT_WAIT}) $display("FAIL midreset_cmds: got %b/%b want Wait", cmd1_s, cmd2_s); else n_pass++;
      n_checks++; if ({bus.round_num, bus.round_timer, bus.match_over} !== {3'd0, 7'd60, 1'b0}) $display("FAIL midreset_state: got round=%0d timer=%0d over=%0b want 0/60/0", bus.round_num, bus.round_timer, bus.match_over); else n_pass++;
      rst = 1'b0;
      step(1'b0);
      step(1'b1);
      n_checks++; if ({cmd1_s, bus.round_num} !== {ACT_WAIT, 3'd0}) $display("FAIL midreset_idle: got cmd=%b round=%0d want Wait/0", cmd1_s, bus.round_num); else n_pass++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst                = 1'b1;
      bus.tick           = 1'b0;
      bus.start          = 1'b0;
      bus.player1_in     = 6'd0;
      bus.player2_in     = 6'd0;
      bus.player1_health = 2'd3;
      bus.player2_health = 2'd3;
`ifdef PAUSE_EN
      bus.pause          = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_start();
      test_actions();
      test_ko();
      test_draw_timeout();
      test_ko_beats_timeout();
      test_timeout_win();
      test_p2_match();
      test_round_cap();
      test_reset_mid_round();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
